// File: rtl/psram_pkg.sv
// Shared PSRAM command set and responder state encoding; the controller header
// uses the same command constants.
package psram_pkg;

    typedef enum logic [2:0] {
        sIdle, sSpiCmd, sQpiCmd, sAddr, sWait, sRead, sWrite, sIgnore
    } ResponderState;

    localparam logic [7:0] enableQPIModeCmd = 8'h35;
    localparam logic [7:0] SPIQuadWrite     = 8'h38;
    localparam logic [7:0] SPIQuadRead      = 8'hEB;
    localparam logic [7:0] exitQPICmd       = 8'hF5;
    localparam logic [7:0] resetEnableCmd   = 8'h66;
    localparam logic [7:0] resetCmd         = 8'h99;

    localparam int WAITCYCLES = 6;

endpackage

// File: rtl/psram_byte_array.sv
// Backing store for one PSRAM die: synchronous write, combinational read,
// one shared address port.
module psram_byte_array #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [7:0]           wdata_i,
    output logic [7:0]           rdata_o
);

    logic [7:0] mem_q [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/psram_qpi_responder.sv
// Cycle-level device-side model of an LY68S3200-style QPI PSRAM die: SPI/QPI
// command decode, 0x38 quad write and 0xEB quad read into a local byte array.
module psram_qpi_responder
    import psram_pkg::*;
#(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_CYCLES = WAITCYCLES,
    parameter int PAGE_BITS   = 10
) (
    input  logic        i_clkRAM,
    input  logic        reset,
    input  logic        i_psram_cs,
    inout  wire  [3:0]  io_sio,
    output logic        o_qpiMode,
    output logic        o_frameActive,
    output logic [7:0]  o_cmd,
    output logic [15:0] o_wrCount
);

    ResponderState state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] addr_q, addr_d;
    logic [3:0]  hi_q, hi_d;
    logic        phase_q, phase_d;
    logic        oe_q, oe_d;
    logic [3:0]  dout_q, dout_d;
    logic        qpi_q, qpi_d;
    logic        armed_q, armed_d;
    logic [7:0]  cmdOut_q, cmdOut_d;
    logic [15:0] wrCount_q, wrCount_d;

    logic                 memWe;
    logic [ADDR_BITS-1:0] memAddr;
    logic [7:0]           memRd;
    logic                 doneCmd;
    logic [7:0]           newCmd;

    // Bursts wrap inside the page; bits above the page are held.
    function automatic logic [23:0] pageInc(input logic [23:0] a);
        logic [23:0] r;
        r = a;
        r[PAGE_BITS-1:0] = a[PAGE_BITS-1:0] + 1'b1;
        return r;
    endfunction

    psram_byte_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk_i   (i_clkRAM),
        .we_i    (memWe),
        .addr_i  (memAddr),
        .wdata_i ({hi_q, io_sio}),
        .rdata_o (memRd)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        hi_d      = hi_q;
        phase_d   = phase_q;
        oe_d      = oe_q;
        dout_d    = dout_q;
        qpi_d     = qpi_q;
        armed_d   = armed_q;
        cmdOut_d  = cmdOut_q;
        wrCount_d = wrCount_q;
        memWe     = 1'b0;
        memAddr   = addr_q[ADDR_BITS-1:0];
        doneCmd   = 1'b0;
        newCmd    = cmd_q;
        if (i_psram_cs) begin
            state_d = sIdle;
            oe_d    = 1'b0;
            cnt_d   = 8'd0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                sIdle: begin
                    if (qpi_q) begin
                        cmd_d   = {4'h0, io_sio};
                        state_d = sQpiCmd;
                    end else begin
                        cmd_d   = {7'h0, io_sio[0]};
                        cnt_d   = 8'd1;
                        state_d = sSpiCmd;
                    end
                end
                sSpiCmd: begin
                    newCmd = {cmd_q[6:0], io_sio[0]};
                    cmd_d  = newCmd;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'd7) begin
                        doneCmd = 1'b1;
                        state_d = sIgnore;
                    end
                end
                sQpiCmd: begin
                    newCmd  = {cmd_q[3:0], io_sio};
                    cmd_d   = newCmd;
                    doneCmd = 1'b1;
                    cnt_d   = 8'd0;
                    if (newCmd == SPIQuadWrite || newCmd == SPIQuadRead) state_d = sAddr;
                    else state_d = sIgnore;
                end
                sAddr: begin
                    addr_d = {addr_q[19:0], io_sio};
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == 8'd5) begin
                        phase_d = 1'b0;
                        if (cmd_q == SPIQuadWrite) begin
                            state_d = sWrite;
                        end else begin
                            state_d = sWait;
                            cnt_d   = 8'(WAIT_CYCLES);
                        end
                    end
                end
                sWait: begin
                    // Drive the first high nibble one edge ahead of the controller's sample.
                    if (cnt_q <= 8'd1) begin
                        oe_d    = 1'b1;
                        dout_d  = memRd[7:4];
                        phase_d = 1'b0;
                        state_d = sRead;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                sRead: begin
                    if (!phase_q) begin
                        dout_d  = memRd[3:0];
                        phase_d = 1'b1;
                    end else begin
                        addr_d  = pageInc(addr_q);
                        memAddr = addr_d[ADDR_BITS-1:0];
                        dout_d  = memRd[7:4];
                        phase_d = 1'b0;
                    end
                end
                sWrite: begin
                    if (!phase_q) begin
                        hi_d    = io_sio;
                        phase_d = 1'b1;
                    end else begin
                        memWe     = 1'b1;
                        wrCount_d = wrCount_q + 16'd1;
                        addr_d    = pageInc(addr_q);
                        phase_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (doneCmd) begin
            cmdOut_d = newCmd;
            armed_d  = (newCmd == resetEnableCmd);
            if (state_q == sSpiCmd && newCmd == enableQPIModeCmd) qpi_d = 1'b1;
            if (newCmd == resetCmd && armed_q) qpi_d = 1'b0;
            if (state_q == sQpiCmd && newCmd == exitQPICmd) qpi_d = 1'b0;
        end
    end

    always_ff @(posedge i_clkRAM) begin
        if (!reset) begin
            state_q   <= sIdle;
            cnt_q     <= 8'd0;
            cmd_q     <= 8'd0;
            addr_q    <= 24'd0;
            hi_q      <= 4'd0;
            phase_q   <= 1'b0;
            oe_q      <= 1'b0;
            dout_q    <= 4'd0;
            qpi_q     <= 1'b0;
            armed_q   <= 1'b0;
            cmdOut_q  <= 8'd0;
            wrCount_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            hi_q      <= hi_d;
            phase_q   <= phase_d;
            oe_q      <= oe_d;
            dout_q    <= dout_d;
            qpi_q     <= qpi_d;
            armed_q   <= armed_d;
            cmdOut_q  <= cmdOut_d;
            wrCount_q <= wrCount_d;
        end
    end

    assign io_sio        = oe_q ? dout_q : 4'bz;
    assign o_qpiMode     = qpi_q;
    assign o_cmd         = cmdOut_q;
    assign o_wrCount     = wrCount_q;
    assign o_frameActive = (state_q == sQpiCmd) || (state_q == sAddr) || (state_q == sWait) ||
                           (state_q == sRead) || (state_q == sWrite);

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder: SPI/QPI command decode, write/read
// bursts, page wrap, aborted frames.
module tb_psram_qpi_responder;
    import psram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        tbOe = 1'b0;
    logic [3:0]  tbD = 4'h0;
    wire  [3:0]  sio;
    logic        qpiMode, frameActive;
    logic [7:0]  cmd;
    logic [15:0] wrCount;

    int checks = 0;
    int errors = 0;
    int oeCnt = 0;
    int oeBase;
    logic [7:0] rb;

    assign sio = tbOe ? tbD : 4'bz;

    always #5 clk = ~clk;

    psram_qpi_responder dut (
        .i_clkRAM      (clk),
        .reset         (rst_n),
        .i_psram_cs    (cs),
        .io_sio        (sio),
        .o_qpiMode     (qpiMode),
        .o_frameActive (frameActive),
        .o_cmd         (cmd),
        .o_wrCount     (wrCount)
    );

    always @(negedge clk) if (dut.oe_q) oeCnt <= oeCnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic nib(input logic [3:0] v);
        @(negedge clk); cs = 1'b0; tbOe = 1'b1; tbD = v;
        @(posedge clk);
    endtask

    task automatic floatNib();
        @(negedge clk); cs = 1'b0; tbOe = 1'b0;
        @(posedge clk);
    endtask

    task automatic csHigh();
        @(negedge clk); cs = 1'b1; tbOe = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic spiCmd(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) nib({3'b000, b[i]});
        csHigh();
    endtask

    task automatic qpiHdr(input logic [7:0] c, input logic [23:0] a);
        nib(c[7:4]); nib(c[3:0]);
        for (int i = 5; i >= 0; i--) nib(a[4*i +: 4]);
    endtask

    task automatic qpiWrByte(input logic [7:0] b);
        nib(b[7:4]); nib(b[3:0]);
    endtask

    task automatic readStart(input logic [23:0] a);
        qpiHdr(SPIQuadRead, a);
        for (int i = 0; i < 6; i++) floatNib();
    endtask

    task automatic rdByte(output logic [7:0] b);
        @(negedge clk); b[7:4] = sio;
        @(posedge clk);
        @(negedge clk); b[3:0] = sio;
        @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_qpi", 32'(qpiMode), 32'd0);
        chk("rst_active", 32'(frameActive), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_wrcount", 32'(wrCount), 32'd0);
        chk("rst_oe", 32'(dut.oe_q), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(sIdle));

        oeBase = oeCnt;
        spiCmd(8'h35);
        chk("spi35_qpi", 32'(qpiMode), 32'd1);
        chk("spi35_cmd", 32'(cmd), 32'h35);
        chk("spi35_noz", 32'(oeCnt - oeBase), 32'd0);

        qpiHdr(SPIQuadWrite, 24'h000123);
        qpiWrByte(8'hA5);
        #1 chk("wr_active", 32'(frameActive), 32'd1);
        csHigh();
        chk("wr_mem123", 32'(dut.u_array.mem_q[12'h123]), 32'hA5);
        chk("wr_count1", 32'(wrCount), 32'd1);

        readStart(24'h000123);
        rdByte(rb);
        chk("rd_123", 32'(rb), 32'hA5);
        csHigh();
        chk("rd_oe_off", 32'(dut.oe_q), 32'd0);

        qpiHdr(SPIQuadWrite, 24'h0003FF);
        qpiWrByte(8'h11);
        qpiWrByte(8'h22);
        csHigh();
        chk("wrap_mem3ff", 32'(dut.u_array.mem_q[12'h3FF]), 32'h11);
        chk("wrap_mem000", 32'(dut.u_array.mem_q[12'h000]), 32'h22);
        chk("wrap_count", 32'(wrCount), 32'd3);

        readStart(24'h0003FF);
        rdByte(rb);
        chk("wrap_rd0", 32'(rb), 32'h11);
        rdByte(rb);
        chk("wrap_rd1", 32'(rb), 32'h22);
        csHigh();

        qpiHdr(SPIQuadWrite, 24'h000040);
        qpiWrByte(8'h5A);
        csHigh();
        qpiHdr(SPIQuadWrite, 24'h000040);
        nib(4'h3);
        csHigh();
        chk("odd_mem040", 32'(dut.u_array.mem_q[12'h040]), 32'h5A);
        chk("odd_count", 32'(wrCount), 32'd4);
        readStart(24'h000040);
        rdByte(rb);
        chk("odd_rd040", 32'(rb), 32'h5A);
        csHigh();

        oeBase = oeCnt;
        qpiHdr(SPIQuadRead, 24'h000123);
        floatNib(); floatNib();
        csHigh();
        chk("abort_state", 32'(dut.state_q), 32'(sIdle));
        chk("abort_active", 32'(frameActive), 32'd0);
        repeat (4) @(posedge clk);
        #1 chk("abort_noz", 32'(oeCnt - oeBase), 32'd0);

        nib(4'hF); nib(4'h5);
        csHigh();
        chk("f5_qpi", 32'(qpiMode), 32'd0);
        chk("f5_cmd", 32'(cmd), 32'hF5);

        // QPI-style nibbles while in SPI mode: only SIO0 counts, giving 0x85.
        nib(4'h3); nib(4'h8); nib(4'h0); nib(4'h0);
        nib(4'h0); nib(4'h1); nib(4'h2); nib(4'h3);
        #1 chk("spiq_state", 32'(dut.state_q), 32'(sIgnore));
        chk("spiq_cmd", 32'(cmd), 32'h85);
        csHigh();
        chk("spiq_count", 32'(wrCount), 32'd4);

        spiCmd(8'h35);
        chk("reenter_qpi", 32'(qpiMode), 32'd1);

        oeBase = oeCnt;
        nib(4'h9); nib(4'hF);
        nib(4'h0); nib(4'h1); nib(4'h2); nib(4'h3);
        #1 chk("unk_state", 32'(dut.state_q), 32'(sIgnore));
        chk("unk_cmd", 32'(cmd), 32'h9F);
        csHigh();
        chk("unk_noz", 32'(oeCnt - oeBase), 32'd0);
        chk("unk_count", 32'(wrCount), 32'd4);
        chk("unk_mem123", 32'(dut.u_array.mem_q[12'h123]), 32'hA5);
        chk("unk_qpi", 32'(qpiMode), 32'd1);

        nib(4'h9); nib(4'h9);
        csHigh();
        chk("99_unarmed_qpi", 32'(qpiMode), 32'd1);
        nib(4'h6); nib(4'h6);
        csHigh();
        chk("66_qpi", 32'(qpiMode), 32'd1);
        nib(4'h9); nib(4'h9);
        csHigh();
        chk("99_qpi", 32'(qpiMode), 32'd0);
        chk("99_cmd", 32'(cmd), 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
